// File: rtl/frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_pkg
// Description : Shared types and helpers for the DDR frame-buffer block:
//               per-slot state encoding and the frame size in bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_buffer_pkg;

    // Life cycle of one frame slot in memory
    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } slot_state_t;

    // Bytes occupied by one frame: 4 pixels packed per 8-byte beat
    function automatic int unsigned frame_bytes(input int unsigned res_x,
                                                input int unsigned res_y);
        return ((res_x + 32'd3) / 32'd4) * 32'd8 * res_y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_slot_sched_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sat_cnt
// Description : Up-counter with increment enable that holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] r_cnt;

    // Count enabled increments, stop at the maximum value
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != c_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/frame_slot_sched.sv
`default_nettype none
// ============================================================================
// Module      : frame_slot_sched
// Description : Hands frame slots to the write and read DMA controllers so
//               they never share a slot; the reader always gets the newest
//               complete frame, with drops/repeats absorbing rate mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_slot_sched
    import frame_buffer_pkg::*;
#(
    parameter int START_ADDR    = 0,
    parameter int FRAMES_AMOUNT = 3,
    parameter int FRAME_RES_X   = 1920,
    parameter int FRAME_RES_Y   = 1080,
    parameter int ADDR_WIDTH    = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_req_i,
    input  logic                  wr_done_i,
    output logic                  wr_grant_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    input  logic                  rd_req_i,
    output logic                  rd_grant_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_valid_o,
    output logic                  rd_new_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o,
    output logic [CNT_WIDTH-1:0]  repeat_cnt_o,
    output logic [CNT_WIDTH-1:0]  abort_cnt_o
);

    localparam int                    c_idx_w = $clog2(FRAMES_AMOUNT);
    localparam logic [63:0]           c_bytes = 64'(frame_bytes(FRAME_RES_X, FRAME_RES_Y));
    localparam logic [ADDR_WIDTH-1:0] c_start = ADDR_WIDTH'(START_ADDR);

    if (FRAMES_AMOUNT < 3) begin : g_bad_frames_amount
        $error("frame_slot_sched: FRAMES_AMOUNT must be at least 3");
    end

    // Constant base address of every slot
    logic [ADDR_WIDTH-1:0] w_addr_tbl [FRAMES_AMOUNT];

    for (genvar gi = 0; gi < FRAMES_AMOUNT; gi++) begin : g_addr
        localparam logic [63:0] c_base = 64'(START_ADDR) + 64'(gi) * c_bytes;
        assign w_addr_tbl[gi] = c_base[ADDR_WIDTH-1:0];
    end

    slot_state_t          r_slot_st [FRAMES_AMOUNT];
    slot_state_t          w_slot_nxt [FRAMES_AMOUNT];
    logic [c_idx_w-1:0]   r_latest,  w_latest_nxt;
    logic                 r_wr_held, w_wr_held_nxt;
    logic [c_idx_w-1:0]   r_wr_idx,  w_wr_idx_nxt;
    logic                 r_rd_held, w_rd_held_nxt;
    logic [c_idx_w-1:0]   r_rd_idx,  w_rd_idx_nxt;
    logic                 w_rdy_found;
    logic [c_idx_w-1:0]   w_free_idx;
    logic                 w_rd_valid, w_rd_new;
    logic                 w_drop_inc, w_rep_inc, w_abort_inc;

    // Evaluate reader, write-done and write-request against the pre-cycle
    // slot states; the writer allocates from the post-done free set
    always_comb begin
        w_slot_nxt    = r_slot_st;
        w_latest_nxt  = r_latest;
        w_wr_held_nxt = r_wr_held;
        w_wr_idx_nxt  = r_wr_idx;
        w_rd_held_nxt = r_rd_held;
        w_rd_idx_nxt  = r_rd_idx;
        w_rdy_found   = 1'b0;
        w_free_idx    = '0;
        w_rd_valid    = 1'b0;
        w_rd_new      = 1'b0;
        w_drop_inc    = 1'b0;
        w_rep_inc     = 1'b0;
        w_abort_inc   = 1'b0;

        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            if (r_slot_st[i] == READY) begin
                w_rdy_found = 1'b1;
            end
        end

        // Reader: the READY slot is always the latest completed frame
        if (rd_req_i) begin
            if (w_rdy_found) begin
                w_slot_nxt[r_latest] = READING;
                if (r_rd_held) begin
                    w_slot_nxt[r_rd_idx] = FREE;
                end
                w_rd_held_nxt = 1'b1;
                w_rd_idx_nxt  = r_latest;
                w_rd_valid    = 1'b1;
                w_rd_new      = 1'b1;
            end else if (r_rd_held) begin
                w_rd_valid = 1'b1;
                w_rep_inc  = 1'b1;
            end
        end

        // Writer finished: publish the frame, discard an unread older one
        if (wr_done_i && r_wr_held) begin
            w_slot_nxt[r_wr_idx] = READY;
            w_latest_nxt         = r_wr_idx;
            w_wr_held_nxt        = 1'b0;
            if (w_rdy_found && !rd_req_i) begin
                w_slot_nxt[r_latest] = FREE;
                w_drop_inc           = 1'b1;
            end
        end

        // Lowest-index free slot after the updates above
        for (int i = FRAMES_AMOUNT - 1; i >= 0; i--) begin
            if (w_slot_nxt[i] == FREE) begin
                w_free_idx = c_idx_w'(i);
            end
        end

        // Writer start: re-grant an aborted slot or take a free one
        if (wr_req_i) begin
            if (w_wr_held_nxt) begin
                w_abort_inc = 1'b1;
            end else begin
                w_slot_nxt[w_free_idx] = WRITING;
                w_wr_held_nxt          = 1'b1;
                w_wr_idx_nxt           = w_free_idx;
            end
        end
    end

    // Slot bookkeeping and registered grant responses
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                r_slot_st[i] <= FREE;
            end
            r_latest   <= '0;
            r_wr_held  <= 1'b0;
            r_wr_idx   <= '0;
            r_rd_held  <= 1'b0;
            r_rd_idx   <= '0;
            wr_grant_o <= 1'b0;
            wr_addr_o  <= c_start;
            rd_grant_o <= 1'b0;
            rd_addr_o  <= c_start;
            rd_valid_o <= 1'b0;
            rd_new_o   <= 1'b0;
        end else begin
            r_slot_st  <= w_slot_nxt;
            r_latest   <= w_latest_nxt;
            r_wr_held  <= w_wr_held_nxt;
            r_wr_idx   <= w_wr_idx_nxt;
            r_rd_held  <= w_rd_held_nxt;
            r_rd_idx   <= w_rd_idx_nxt;
            wr_grant_o <= wr_req_i;
            rd_grant_o <= rd_req_i;
            rd_valid_o <= w_rd_valid;
            rd_new_o   <= w_rd_new;
            if (wr_req_i) begin
                wr_addr_o <= w_addr_tbl[w_wr_idx_nxt];
            end
            if (w_rd_valid) begin
                rd_addr_o <= w_addr_tbl[w_rd_idx_nxt];
            end
        end
    end

    sat_cnt #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_drop_inc),
        .cnt_o (drop_cnt_o)
    );

    sat_cnt #(.WIDTH(CNT_WIDTH)) u_repeat_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_rep_inc),
        .cnt_o (repeat_cnt_o)
    );

    sat_cnt #(.WIDTH(CNT_WIDTH)) u_abort_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_abort_inc),
        .cnt_o (abort_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_frame_slot_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_slot_sched
// Description : Directed scoreboard bench for frame_slot_sched with the
//               default 3-slot 1920x1080 configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_slot_sched;

    localparam logic [31:0] c_a0 = 32'h0000_0000;
    localparam logic [31:0] c_a1 = 32'h003F_4800;
    localparam logic [31:0] c_a2 = 32'h007E_9000;

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic        nw;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wr_req_i, wr_done_i, rd_req_i;
    logic        wr_grant_o, rd_grant_o, rd_valid_o, rd_new_o;
    logic [31:0] wr_addr_o, rd_addr_o;
    logic [15:0] drop_cnt_o, repeat_cnt_o, abort_cnt_o;

    logic [31:0] r_wr_q [$];
    rd_exp_t     r_rd_q [$];
    int          r_total = 0;
    int          r_bad   = 0;

    frame_slot_sched u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .wr_req_i     (wr_req_i),
        .wr_done_i    (wr_done_i),
        .wr_grant_o   (wr_grant_o),
        .wr_addr_o    (wr_addr_o),
        .rd_req_i     (rd_req_i),
        .rd_grant_o   (rd_grant_o),
        .rd_addr_o    (rd_addr_o),
        .rd_valid_o   (rd_valid_o),
        .rd_new_o     (rd_new_o),
        .drop_cnt_o   (drop_cnt_o),
        .repeat_cnt_o (repeat_cnt_o),
        .abort_cnt_o  (abort_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        r_total++;
        if (got !== exp) begin
            r_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, then compare the grants one cycle later
    task automatic cyc(input logic w, input logic d, input logic r);
        logic [31:0] v_wa;
        rd_exp_t     v_re;
        wr_req_i  = w;
        wr_done_i = d;
        rd_req_i  = r;
        @(posedge clk);
        #1;
        wr_req_i  = 1'b0;
        wr_done_i = 1'b0;
        rd_req_i  = 1'b0;
        chk("wr_grant", wr_grant_o, w);
        chk("rd_grant", rd_grant_o, r);
        if (w) begin
            if (r_wr_q.size() == 0) begin
                chk("wr_queue_empty", 1, 0);
            end else begin
                v_wa = r_wr_q.pop_front();
                chk("wr_addr", wr_addr_o, v_wa);
            end
        end
        if (r) begin
            if (r_rd_q.size() == 0) begin
                chk("rd_queue_empty", 1, 0);
            end else begin
                v_re = r_rd_q.pop_front();
                chk("rd_valid", rd_valid_o, v_re.valid);
                chk("rd_new", rd_new_o, v_re.nw);
                if (v_re.valid) begin
                    chk("rd_addr", rd_addr_o, v_re.addr);
                end
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_grant"}, wr_grant_o, 0);
        chk({tag, "_rd_grant"}, rd_grant_o, 0);
        chk({tag, "_rd_valid"}, rd_valid_o, 0);
        chk({tag, "_rd_new"}, rd_new_o, 0);
        chk({tag, "_wr_addr"}, wr_addr_o, c_a0);
        chk({tag, "_rd_addr"}, rd_addr_o, c_a0);
        chk({tag, "_drop"}, drop_cnt_o, 0);
        chk({tag, "_repeat"}, repeat_cnt_o, 0);
        chk({tag, "_abort"}, abort_cnt_o, 0);
    endtask

    initial begin
        rst_i     = 1'b0;
        wr_req_i  = 1'b0;
        wr_done_i = 1'b0;
        rd_req_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_i = 1'b1;

        // Read before any frame exists, then first write slot
        r_rd_q.push_back('{addr: 32'h0, valid: 1'b0, nw: 1'b0});
        cyc(0, 0, 1);
        r_wr_q.push_back(c_a0);
        cyc(1, 0, 0);

        // Complete, read it, next writer slot
        cyc(0, 1, 0);
        r_rd_q.push_back('{addr: c_a0, valid: 1'b1, nw: 1'b1});
        cyc(0, 0, 1);
        r_wr_q.push_back(c_a1);
        cyc(1, 0, 0);

        // Three completed frames without a read: two drops
        cyc(0, 1, 0);
        r_wr_q.push_back(c_a2);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        r_wr_q.push_back(c_a1);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("drop_after_3", drop_cnt_o, 2);
        r_rd_q.push_back('{addr: c_a1, valid: 1'b1, nw: 1'b1});
        cyc(0, 0, 1);

        // One frame, four back-to-back reads: one new, three repeats
        r_wr_q.push_back(c_a0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        r_rd_q.push_back('{addr: c_a0, valid: 1'b1, nw: 1'b1});
        for (int i = 0; i < 3; i++) begin
            r_rd_q.push_back('{addr: c_a0, valid: 1'b1, nw: 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1);
        end
        chk("repeat_3", repeat_cnt_o, 3);

        // Aborted frame: second request re-grants the same slot
        r_wr_q.push_back(c_a1);
        cyc(1, 0, 0);
        r_wr_q.push_back(c_a1);
        cyc(1, 0, 0);
        chk("abort_1", abort_cnt_o, 1);

        // Done and read together: reader repeats, new frame on next read
        r_rd_q.push_back('{addr: c_a0, valid: 1'b1, nw: 1'b0});
        cyc(0, 1, 1);
        r_rd_q.push_back('{addr: c_a1, valid: 1'b1, nw: 1'b1});
        cyc(0, 0, 1);
        chk("repeat_4", repeat_cnt_o, 4);

        // Done with request: allocate from post-done free set
        r_wr_q.push_back(c_a0);
        cyc(1, 0, 0);
        r_wr_q.push_back(c_a2);
        cyc(1, 1, 0);
        // Writer request (abort) together with reader taking the new frame
        r_wr_q.push_back(c_a2);
        r_rd_q.push_back('{addr: c_a0, valid: 1'b1, nw: 1'b1});
        cyc(1, 0, 1);
        chk("abort_2", abort_cnt_o, 2);
        chk("drop_still_2", drop_cnt_o, 2);

        // Reset mid-frame with a request pending
        rst_i    = 1'b0;
        wr_req_i = 1'b1;
        rd_req_i = 1'b1;
        @(posedge clk);
        #1;
        wr_req_i = 1'b0;
        rd_req_i = 1'b0;
        chk_reset_outputs("midreset");
        rst_i = 1'b1;

        // Everything cleared: reader gets nothing, writer gets slot 0
        r_rd_q.push_back('{addr: 32'h0, valid: 1'b0, nw: 1'b0});
        cyc(0, 0, 1);
        r_wr_q.push_back(c_a0);
        cyc(1, 0, 0);
        chk("post_reset_repeat", repeat_cnt_o, 0);

        chk("wr_queue_drained", r_wr_q.size(), 0);
        chk("rd_queue_drained", r_rd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
